// File: rtl/enemy_bomb_controller.sv
// enemy_bomb_controller
//   Drops bombs downward from a shooter position toward the spaceship.
//   Keeps a pool of NUM_BOMBS slots. Each frame it launches new bombs,
//   moves every falling bomb down, and retires bombs that leave the bottom
//   of the screen or that hit the player. It also drives the pixel-scan
//   drawing request and colour.
//
// Ports
//   clk           system clock
//   resetN        synchronous active-low reset
//   startOfFrame  one-cycle pulse per frame
//   pixelX/Y      current scan position
//   shooterX/Y    launch position (bomb top-left)
//   shooterValid  a shooter exists and may fire
//   collision     bomb pixel overlaps the player this cycle
//   bombDR        drawing request (1-cycle latency)
//   bombRGB       bomb colour, 8'hFF when bombDR=0
//   bombFired     one-cycle pulse per launch
//   activeCount   registered count of active slots
module enemy_bomb_controller #(
  parameter int unsigned NUM_BOMBS     = 4,
  parameter int unsigned BOMB_WIDTH    = 4,
  parameter int unsigned BOMB_HEIGHT   = 8,
  parameter int unsigned SPEED_Y       = 2,
  parameter int unsigned SCREEN_BOTTOM = 479,
  parameter int unsigned FIRE_PERIOD   = 32,
  parameter logic [15:0] FIRE_MASK     = 16'h0003,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic [7:0]  BOMB_COLOR    = 8'hE0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] shooterX,
  input  logic [10:0] shooterY,
  input  logic        shooterValid,
  input  logic        collision,
  output logic        bombDR,
  output logic [7:0]  bombRGB,
  output logic        bombFired,
  output logic [3:0]  activeCount
);

  typedef enum logic {
    SLOT_IDLE,
    SLOT_FALLING
  } slot_state_t;

  slot_state_t          state_q [NUM_BOMBS];
  slot_state_t          state_d [NUM_BOMBS];
  logic [10:0]          x_q     [NUM_BOMBS];
  logic [10:0]          x_d     [NUM_BOMBS];
  logic [10:0]          y_q     [NUM_BOMBS];
  logic [10:0]          y_d     [NUM_BOMBS];
  logic [15:0]          cooldown_q;
  logic [15:0]          cooldown_d;
  logic [15:0]          lfsr_q;
  logic [15:0]          lfsr_d;
  logic                 fired_d;
  logic [NUM_BOMBS-1:0] hit;
  logic [NUM_BOMBS-1:0] hit_q;
  logic [3:0]           count;
  logic                 any_free;
  logic                 launch;
  logic                 found;
  logic [11:0]          ny;

  // Pixel hit test against the current slot state, 12-bit so x+width never wraps.
  always_comb begin
    hit   = '0;
    count = '0;
    for (int unsigned i = 0; i < NUM_BOMBS; i++) begin
      hit[i] = (state_q[i] == SLOT_FALLING) &&
               ({1'b0, pixelX} >= {1'b0, x_q[i]}) &&
               ({1'b0, pixelX} <  ({1'b0, x_q[i]} + 12'(BOMB_WIDTH))) &&
               ({1'b0, pixelY} >= {1'b0, y_q[i]}) &&
               ({1'b0, pixelY} <  ({1'b0, y_q[i]} + 12'(BOMB_HEIGHT)));
      if (state_q[i] == SLOT_FALLING) begin
        count = count + 4'd1;
      end
    end
  end

  // Next-state: collision retirement outranks the frame move, and free slots
  // are judged from pre-edge state so a slot retired now is not relaunched now.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cooldown_d = cooldown_q;
    lfsr_d     = lfsr_q;
    fired_d    = 1'b0;
    any_free   = 1'b0;
    found      = 1'b0;
    ny         = '0;

    for (int unsigned i = 0; i < NUM_BOMBS; i++) begin
      if (state_q[i] == SLOT_IDLE) begin
        any_free = 1'b1;
      end
    end

    launch = startOfFrame && (cooldown_q == '0) && shooterValid &&
             ((lfsr_q & FIRE_MASK) == '0) && any_free;

    for (int unsigned i = 0; i < NUM_BOMBS; i++) begin
      if (collision && bombDR && hit_q[i]) begin
        state_d[i] = SLOT_IDLE;
      end else if (startOfFrame && (state_q[i] == SLOT_FALLING)) begin
        ny = {1'b0, y_q[i]} + 12'(SPEED_Y);
        if (ny > 12'(SCREEN_BOTTOM)) begin
          state_d[i] = SLOT_IDLE;
        end else begin
          y_d[i] = ny[10:0];
        end
      end
    end

    if (startOfFrame) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      if (launch) begin
        cooldown_d = 16'(FIRE_PERIOD);
        fired_d    = 1'b1;
        for (int unsigned i = 0; i < NUM_BOMBS; i++) begin
          if (!found && (state_q[i] == SLOT_IDLE)) begin
            found      = 1'b1;
            state_d[i] = SLOT_FALLING;
            x_d[i]     = shooterX;
            y_d[i]     = shooterY;
          end
        end
      end else if (cooldown_q != '0) begin
        cooldown_d = cooldown_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < NUM_BOMBS; i++) begin
        state_q[i] <= SLOT_IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
      end
      cooldown_q  <= 16'(FIRE_PERIOD);
      lfsr_q      <= LFSR_SEED;
      hit_q       <= '0;
      bombDR      <= 1'b0;
      bombRGB     <= '1;
      bombFired   <= 1'b0;
      activeCount <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cooldown_q  <= cooldown_d;
      lfsr_q      <= lfsr_d;
      hit_q       <= hit;
      bombDR      <= |hit;
      bombRGB     <= (|hit) ? BOMB_COLOR : 8'hFF;
      bombFired   <= fired_d;
      activeCount <= count;
    end
  end

endmodule
